br_perf_monitor: RTL and testbench
==================================

Name: br_perf_monitor

Overview:
- Bench-side consumer of the per-cycle branch event stream the core top exports (branch-retire strobe, misprediction strobe, IF instruction word).
- Accumulates cycle, branch and misprediction counts across one program run and detects program end from a halt instruction.
- Freezes the totals after the pipeline drains and serves them through a request/valid readout port to the testbench or a host.
- Works with every predictor variant, because it uses only the exported strobes.

Parameters:
- CNT_W, 32, width of every counter and of rd_data_o.
- HALT_INSTR, 32'h0000_006F, instruction word that marks program end (jal x0,0).
- HALT_CYCLES, 8, consecutive cycles HALT_INSTR must be seen before end is declared (range 1..255).
- DRAIN_CYCLES, 4, cycles counted after halt detection so in-flight branches retire (range 0..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- br_instr_i  in  1  branch/jump reached the EX/MEM stage this cycle
- br_misses_i  in  1  branch misprediction (flush) this cycle
- instr_i  in  32  instruction word currently in IF
- clr_i  in  1  synchronous clear: zero all counters, return to IDLE
- rd_req_i  in  1  readout request, one-cycle pulse or held
- rd_sel_i  in  2  counter select: 0=cycles, 1=branches, 2=misses, 3=max miss streak (0 when the optional feature is off)
- rd_data_o  out  CNT_W  selected counter value
- rd_vld_o  out  1  rd_data_o valid
- done_o  out  1  run complete, counters frozen
- sat_o  out  1  sticky: any counter saturated
- state_o  out  2  FSM state: 0=IDLE, 1=RUN, 2=DRAIN, 3=DONE

Behaviour:
- Reset (asynchronous, rst_i=1): state IDLE; all counters, the halt run counter and the drain counter are 0; rd_data_o=0, rd_vld_o=0, done_o=0, sat_o=0.
- IDLE:
  - Counters are held at 0.
  - Moves to RUN on the first cycle with instr_i != 0.
  - That cycle is counted: cycle_cnt=1, and branch and miss counts are taken from the same-cycle strobes.
- RUN:
  - Each cycle: cycle_cnt+1; br_cnt + br_instr_i; miss_cnt + br_misses_i.
  - br_misses_i is counted even when br_instr_i=0, because some variants flag flushes independently.
  - halt_run increments while instr_i==HALT_INSTR; any other word resets it to 0.
  - When halt_run reaches HALT_CYCLES, the state moves to DRAIN on the next edge.
- DRAIN:
  - Counting continues exactly as in RUN for DRAIN_CYCLES cycles, then the state moves to DONE.
  - With DRAIN_CYCLES=0, the state moves RUN to DONE directly.
- DONE:
  - All counters are frozen and done_o=1.
  - The FSM stays in DONE until clr_i or reset.
- Saturation:
  - Each counter stops at 2^CNT_W-1 and does not wrap.
  - sat_o is set on the cycle a counter would overflow and stays set until clr_i or reset.
- clr_i:
  - Takes priority over all other events in the same cycle.
  - Next cycle: state IDLE, counters 0, sat_o=0, done_o=0, and any pending readout is cancelled (rd_vld_o=0).
- Readout:
  - rd_req_i is sampled every cycle, in any state.
  - One cycle later: rd_vld_o=1 and rd_data_o holds the value of counter rd_sel_i as it was at the request edge, before that edge's increment.
  - A held request returns one word per cycle.
  - rd_vld_o=0 in cycles with no request, and rd_data_o keeps its last value.
- Latency: counter updates are visible to readout one cycle after the event cycle.
- Reset mid-run: all state is lost immediately, with no partial readout.

Optional Feature:
- Macro: BR_MON_STREAK_EN.
- Defined:
  - A streak counter counts consecutive cycles with br_misses_i=1 during RUN/DRAIN and resets to 0 on a cycle without a miss.
  - max_streak records the peak streak value, saturating.
  - rd_sel_i=3 returns max_streak.
  - clr_i and reset zero both the streak counter and max_streak.
- Undefined:
  - No streak logic is built.
  - rd_sel_i=3 returns 0, with rd_vld_o behaving as usual.

Test Plan:
- Reset/idle:
  - Stimulus: rst_i pulse, instr_i=0 for 10 cycles, rd_req_i with sel 0.
  - Required: rd_vld_o=1 one cycle later with rd_data_o=0; state_o=0; done_o=0.
- Basic run (HALT_CYCLES=8, DRAIN_CYCLES=4):
  - Stimulus: 20 non-zero instructions; br_instr_i on 5 of them; br_misses_i on 2 of them; then HALT_INSTR held.
  - Required: done_o rises 20+8+4 cycles after the first instr; reads return cycles=32, branches=5, misses=2.
- Broken halt run:
  - Stimulus: HALT_INSTR for 7 cycles, one other word, then HALT_INSTR for 8 cycles.
  - Required: DRAIN is entered only after the second run; cycle_cnt includes all 16 cycles.
- Saturation (CNT_W=4):
  - Stimulus: 20 RUN cycles.
  - Required: cycles reads 15; sat_o=1; a following clr_i clears sat_o and returns state_o to 0.
- Clear/event collision:
  - Stimulus: clr_i and br_misses_i asserted in the same cycle, mid-run.
  - Required: misses reads 0 and state_o=0 the next cycle.
- BR_MON_STREAK_EN defined:
  - Stimulus: miss pattern 1,1,1,0,1,1.
  - Required: rd_sel_i=3 returns 3.
- BR_MON_STREAK_EN undefined:
  - Stimulus: rd_sel_i=3.
  - Required: returns 0 with rd_vld_o=1.

Source files
------------

// File: rtl/br_perf_monitor.sv
// br_perf_monitor: per-run branch statistics (cycles, branches, mispredictions) with
// halt detection, drain window and frozen readout. Define BR_MON_STREAK_EN for max miss streak.
module br_perf_monitor #(
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] HALT_INSTR   = 32'h0000_006F,
  parameter int unsigned HALT_CYCLES  = 8,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             br_instr_i,
  input  logic             br_misses_i,
  input  logic [31:0]      instr_i,
  input  logic             clr_i,
  input  logic             rd_req_i,
  input  logic [1:0]       rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             rd_vld_o,
  output logic             done_o,
  output logic             sat_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NCNT = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [8:0] HALT_TGT = 9'(HALT_CYCLES);
  localparam int unsigned DRAIN_LAST_I = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_LAST_I);

  state_t           state_reg, state_next;
  logic [7:0]       halt_run_reg, halt_run_next;
  logic [3:0]       drain_cnt_reg, drain_cnt_next;
  logic             sat_reg, sat_next;
  logic             rd_vld_reg;
  logic [CNT_W-1:0] rd_data_reg;

  logic             instr_nz;
  logic             is_halt;
  logic             halt_hit;
  logic             cnt_en;
  logic [8:0]       halt_inc;
  logic [NCNT-1:0]  cnt_ev;
  logic [NCNT-1:0]  cnt_ovf;
  logic [CNT_W-1:0] cnt_val [NCNT];
  logic [CNT_W-1:0] max_streak_val;
  logic             streak_ovf;
  logic [CNT_W-1:0] rd_mux;

  assign instr_nz = |instr_i;
  assign is_halt  = (instr_i == HALT_INSTR);
  assign halt_inc = {1'b0, halt_run_reg} + 9'd1;
  assign halt_hit = is_halt && (halt_inc >= HALT_TGT);

  // The IDLE->RUN cycle is itself counted, so counting is enabled on that edge too.
  assign cnt_en = (state_reg == RUN) || (state_reg == DRAIN) ||
                  ((state_reg == IDLE) && instr_nz);

  // Counter order: 0 = cycles, 1 = branches, 2 = misses (matches rd_sel_i).
  assign cnt_ev = {br_misses_i, br_instr_i, 1'b1};

  always_comb begin
    state_next     = state_reg;
    halt_run_next  = halt_run_reg;
    drain_cnt_next = drain_cnt_reg;
    if (clr_i) begin
      state_next     = IDLE;
      halt_run_next  = 8'd0;
      drain_cnt_next = 4'd0;
    end else begin
      case (state_reg)
        IDLE, RUN: begin
          if (cnt_en) begin
            if (!is_halt) begin
              halt_run_next = 8'd0;
            end else if (halt_run_reg == 8'hFF) begin
              halt_run_next = 8'hFF;
            end else begin
              halt_run_next = halt_inc[7:0];
            end
            drain_cnt_next = 4'd0;
            if (halt_hit) begin
              state_next = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
            end else begin
              state_next = RUN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_next = DONE;
          end else begin
            drain_cnt_next = drain_cnt_reg + 4'd1;
          end
        end
        default: begin
          state_next = DONE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             ovf;

      // Saturating increment; the would-be overflow is reported instead of wrapping.
      always_comb begin
        cnt_next = cnt_reg;
        ovf      = 1'b0;
        if (clr_i) begin
          cnt_next = '0;
        end else if (cnt_en && cnt_ev[gi]) begin
          if (cnt_reg == CNT_MAX) begin
            ovf = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign cnt_val[gi] = cnt_reg;
      assign cnt_ovf[gi] = ovf;
    end
  endgenerate

`ifdef BR_MON_STREAK_EN
  logic [CNT_W-1:0] streak_reg, streak_next;
  logic [CNT_W-1:0] max_streak_reg, max_streak_next;

  always_comb begin
    streak_next     = streak_reg;
    max_streak_next = max_streak_reg;
    streak_ovf      = 1'b0;
    if (clr_i) begin
      streak_next     = '0;
      max_streak_next = '0;
    end else if (cnt_en) begin
      if (!br_misses_i) begin
        streak_next = '0;
      end else if (streak_reg == CNT_MAX) begin
        streak_ovf = 1'b1;
      end else begin
        streak_next = streak_reg + CNT_ONE;
      end
      if (streak_next > max_streak_reg) begin
        max_streak_next = streak_next;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_reg     <= '0;
      max_streak_reg <= '0;
    end else begin
      streak_reg     <= streak_next;
      max_streak_reg <= max_streak_next;
    end
  end

  assign max_streak_val = max_streak_reg;
`else
  assign max_streak_val = '0;
  assign streak_ovf     = 1'b0;
`endif

  assign sat_next = clr_i ? 1'b0 : (sat_reg | (|cnt_ovf) | streak_ovf);

  // Readout captures the pre-increment register value of the request edge.
  always_comb begin
    rd_mux = '0;
    case (rd_sel_i)
      2'd0:    rd_mux = cnt_val[0];
      2'd1:    rd_mux = cnt_val[1];
      2'd2:    rd_mux = cnt_val[2];
      default: rd_mux = max_streak_val;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      halt_run_reg  <= 8'd0;
      drain_cnt_reg <= 4'd0;
      sat_reg       <= 1'b0;
      rd_vld_reg    <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      halt_run_reg  <= halt_run_next;
      drain_cnt_reg <= drain_cnt_next;
      sat_reg       <= sat_next;
      rd_vld_reg    <= rd_req_i && !clr_i;
      if (rd_req_i && !clr_i) begin
        rd_data_reg <= rd_mux;
      end
    end
  end

  assign rd_data_o = rd_data_reg;
  assign rd_vld_o  = rd_vld_reg;
  assign done_o    = (state_reg == DONE);
  assign sat_o     = sat_reg;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_br_perf_monitor.sv
// Testbench for br_perf_monitor: a 32-bit and a 4-bit instance share one stimulus
// stream; expectations come from window sums over the recorded program.
module tb_br_perf_monitor;
  localparam logic [31:0] HALT = 32'h0000_006F;
  localparam int HC = 8;
  localparam int DC = 4;
  localparam int PMAX = 128;
`ifdef BR_MON_STREAK_EN
  localparam longint STREAK3 = 3;
`else
  localparam longint STREAK3 = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        br_instr_i;
  logic        br_misses_i;
  logic        clr_i;
  logic        rd_req_i;
  logic [31:0] instr_i;
  logic [1:0]  rd_sel_i;
  logic [31:0] rd_data;
  logic        rd_vld, done, sat;
  logic [1:0]  state;
  logic [3:0]  rd_data_s;
  logic        rd_vld_s, done_s, sat_s;
  logic [1:0]  state_s;

  int total = 0;
  int bad = 0;

  logic [31:0] p_instr [PMAX];
  bit          p_br    [PMAX];
  bit          p_miss  [PMAX];
  bit          p_req   [PMAX];
  logic [1:0]  p_sel   [PMAX];
  int          p_len;
  int          s_idx, h_idx, e_idx;
  longint      exp_data, exp_data_s;

  always #5 clk_i = ~clk_i;

  br_perf_monitor dut (
    .clk_i(clk_i), .rst_i(rst_i), .br_instr_i(br_instr_i), .br_misses_i(br_misses_i),
    .instr_i(instr_i), .clr_i(clr_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
    .rd_data_o(rd_data), .rd_vld_o(rd_vld), .done_o(done), .sat_o(sat), .state_o(state)
  );

  br_perf_monitor #(.CNT_W(4)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .br_instr_i(br_instr_i), .br_misses_i(br_misses_i),
    .instr_i(instr_i), .clr_i(clr_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
    .rd_data_o(rd_data_s), .rd_vld_o(rd_vld_s), .done_o(done_s), .sat_o(sat_s), .state_o(state_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == 32'd0 || w == HALT);
    return w;
  endfunction

  function automatic bit rb(input int n);
    return ($urandom_range(0, n - 1) == 0);
  endfunction

  task automatic push(input logic [31:0] w, input bit br, input bit miss, input bit req);
    p_instr[p_len] = w;
    p_br[p_len]    = br;
    p_miss[p_len]  = miss;
    p_req[p_len]   = req;
    p_sel[p_len]   = 2'($urandom_range(0, 3));
    p_len++;
  endtask

  // Run start, halt detection point and last counted cycle of the recorded program.
  task automatic analyze();
    int run;
    s_idx = PMAX * 4;
    h_idx = PMAX * 4;
    for (int i = 0; i < p_len; i++) begin
      if (p_instr[i] != 32'd0) begin
        s_idx = i;
        break;
      end
    end
    run = 0;
    for (int i = s_idx; i < p_len; i++) begin
      run = (p_instr[i] == HALT) ? run + 1 : 0;
      if (run == HC) begin
        h_idx = i;
        break;
      end
    end
    e_idx = h_idx + DC;
  endtask

  function automatic int exp_state(input int i);
    if (i < s_idx) return 0;
    if (i < h_idx) return 1;
    if (i < e_idx) return 2;
    return 3;
  endfunction

  // Unsaturated totals over counted cycles s_idx..min(k, e_idx).
  function automatic longint raw(input int sel, input int k);
    int hi;
    longint r;
    longint run;
    hi = (k < e_idx) ? k : e_idx;
    r = 0;
    run = 0;
    if (hi < s_idx) return 0;
`ifndef BR_MON_STREAK_EN
    if (sel == 3) return 0;
`endif
    for (int j = s_idx; j <= hi; j++) begin
      case (sel)
        0: r++;
        1: r += longint'(p_br[j]);
        2: r += longint'(p_miss[j]);
        default: begin
          run = p_miss[j] ? run + 1 : 0;
          if (run > r) r = run;
        end
      endcase
    end
    return r;
  endfunction

  function automatic longint capv(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic idle_inputs();
    instr_i = 32'd0;
    br_instr_i = 1'b0;
    br_misses_i = 1'b0;
    clr_i = 1'b0;
    rd_req_i = 1'b0;
    rd_sel_i = 2'd0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_state_s"}, 64'(state_s), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_sat"}, 64'(sat), 64'd0);
    check({tag, "_sat_s"}, 64'(sat_s), 64'd0);
    check({tag, "_vld"}, 64'(rd_vld), 64'd0);
    check({tag, "_vld_s"}, 64'(rd_vld_s), 64'd0);
    check({tag, "_data"}, 64'(rd_data), 64'(exp_data));
    check({tag, "_data_s"}, 64'(rd_data_s), 64'(exp_data_s));
  endtask

  task automatic run_prog(input int clr_at);
    int es;
    analyze();
    for (int i = 0; i < p_len; i++) begin
      instr_i = p_instr[i];
      br_instr_i = p_br[i];
      br_misses_i = p_miss[i];
      rd_req_i = p_req[i];
      rd_sel_i = p_sel[i];
      clr_i = (i == clr_at);
      @(posedge clk_i);
      #1;
      if (i == clr_at) begin
        check_cleared($sformatf("clr_mid@%0d", i));
        break;
      end
      es = exp_state(i);
      check($sformatf("state@%0d", i), 64'(state), 64'(es));
      check($sformatf("state_s@%0d", i), 64'(state_s), 64'(es));
      check($sformatf("done@%0d", i), 64'(done), 64'(es == 3));
      if (p_req[i]) begin
        exp_data = capv(raw(p_sel[i], i - 1), 32);
        exp_data_s = capv(raw(p_sel[i], i - 1), 4);
      end
      check($sformatf("vld@%0d", i), 64'(rd_vld), 64'(p_req[i]));
      check($sformatf("vld_s@%0d", i), 64'(rd_vld_s), 64'(p_req[i]));
      check($sformatf("data@%0d", i), 64'(rd_data), 64'(exp_data));
      check($sformatf("data_s@%0d", i), 64'(rd_data_s), 64'(exp_data_s));
      check($sformatf("sat@%0d", i), 64'(sat), 64'(raw(0, i) > capv(64'hFFFF_FFFF_FFFF, 32)));
      check($sformatf("sat_s@%0d", i), 64'(sat_s), 64'(raw(0, i) > 15));
    end
    idle_inputs();
  endtask

  task automatic rd(input logic [1:0] sel, input longint e32, input longint e4, input string tag);
    rd_req_i = 1'b1;
    rd_sel_i = sel;
    @(posedge clk_i);
    #1;
    rd_req_i = 1'b0;
    exp_data = e32;
    exp_data_s = e4;
    check({tag, "_vld"}, 64'(rd_vld), 64'd1);
    check({tag, "_vld_s"}, 64'(rd_vld_s), 64'd1);
    check({tag, "_data"}, 64'(rd_data), 64'(e32));
    check({tag, "_data_s"}, 64'(rd_data_s), 64'(e4));
  endtask

  // Clear with colliding strobes and a readout request that must be cancelled.
  task automatic do_clr(input string tag);
    clr_i = 1'b1;
    rd_req_i = 1'b1;
    rd_sel_i = 2'($urandom_range(0, 3));
    br_instr_i = 1'b1;
    br_misses_i = 1'b1;
    instr_i = rand_word();
    @(posedge clk_i);
    #1;
    check_cleared(tag);
    idle_inputs();
  endtask

  task automatic read_all(input string tag);
    for (int sel = 0; sel < 4; sel++) begin
      rd(2'(sel), capv(raw(sel, PMAX), 32), capv(raw(sel, PMAX), 4), $sformatf("%s_sel%0d", tag, sel));
    end
  endtask

  task automatic gen_random(input int idle_n, input int body_n, input bit broken);
    p_len = 0;
    for (int i = 0; i < idle_n; i++) push(32'd0, rb(2), rb(2), rb(2));
    for (int i = 0; i < body_n; i++) push(rand_word(), rb(3), rb(4), rb(2));
    if (broken) begin
      for (int i = 0; i < HC - 1; i++) push(HALT, rb(3), rb(4), rb(2));
      push(rand_word(), rb(3), rb(4), rb(2));
    end
    for (int i = 0; i < HC + DC + 3; i++) push(HALT, rb(3), rb(4), rb(2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idle_n;
    int clr_at;
    rst_i = 1'b1;
    idle_inputs();
    exp_data = 0;
    exp_data_s = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_cleared("reset");
    rst_i = 1'b0;

    // Reset/idle: zero instructions keep the monitor idle and counters at zero.
    repeat (10) @(posedge clk_i);
    #1;
    check("idle_state", 64'(state), 64'd0);
    rd(2'd0, 0, 0, "idle_cycles");
    check("idle_done", 64'(done), 64'd0);

    // Basic run: 20 words, 5 branches, 2 misses, then halt held.
    p_len = 0;
    for (int i = 0; i < 20; i++) push(rand_word(), (i % 4 == 0), (i == 6 || i == 13), 1'b0);
    for (int i = 0; i < HC + DC + 3; i++) push(HALT, 1'b0, 1'b0, 1'b0);
    run_prog(-1);
    rd(2'd0, 32, 15, "basic_cycles");
    rd(2'd1, 5, 5, "basic_branches");
    rd(2'd2, 2, 2, "basic_misses");
    check("basic_sat", 64'(sat), 64'd0);
    check("basic_sat_s", 64'(sat_s), 64'd1);
    check("basic_done", 64'(done), 64'd1);
    do_clr("basic_clr");

    // Broken halt run: 3 words, 7 halts, one word, then 8 halts and drain.
    p_len = 0;
    for (int i = 0; i < 3; i++) push(rand_word(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < HC - 1; i++) push(HALT, 1'b0, 1'b0, 1'b0);
    push(rand_word(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < HC + DC + 3; i++) push(HALT, 1'b0, 1'b0, 1'b0);
    run_prog(-1);
    rd(2'd0, 23, 15, "broken_cycles");
    do_clr("broken_clr");

    // Miss streak pattern 1,1,1,0,1,1.
    p_len = 0;
    push(32'd0, 1'b0, 1'b1, 1'b0);
    push(rand_word(), 1'b1, 1'b1, 1'b0);
    push(rand_word(), 1'b0, 1'b1, 1'b0);
    push(rand_word(), 1'b1, 1'b1, 1'b0);
    push(rand_word(), 1'b0, 1'b0, 1'b0);
    push(rand_word(), 1'b0, 1'b1, 1'b0);
    push(rand_word(), 1'b0, 1'b1, 1'b0);
    push(rand_word(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < HC + DC + 3; i++) push(HALT, 1'b0, 1'b0, 1'b0);
    run_prog(-1);
    rd(2'd3, STREAK3, STREAK3, "streak");
    rd(2'd2, 5, 5, "streak_misses");
    do_clr("streak_clr");

    // Randomized runs with concurrent readout traffic.
    for (int r = 0; r < 12; r++) begin
      gen_random($urandom_range(0, 5), $urandom_range(1, 40), rb(2));
      run_prog(-1);
      read_all($sformatf("rnd%0d", r));
      do_clr($sformatf("rnd%0d_clr", r));
    end

    // Clear colliding with a miss mid-run.
    idle_n = $urandom_range(0, 4);
    gen_random(idle_n, 12, 1'b0);
    clr_at = idle_n + $urandom_range(2, 10);
    p_miss[clr_at] = 1'b1;
    p_br[clr_at] = 1'b1;
    run_prog(clr_at);
    rd(2'd2, 0, 0, "coll_misses");
    check("coll_state", 64'(state), 64'd0);

    // Asynchronous reset mid-run discards everything at once.
    for (int i = 0; i < 5; i++) begin
      instr_i = rand_word();
      br_instr_i = 1'b1;
      br_misses_i = 1'b1;
      rd_req_i = 1'b1;
      rd_sel_i = 2'd0;
      @(posedge clk_i);
      #1;
    end
    check("prerst_state", 64'(state), 64'd1);
    rst_i = 1'b1;
    #1;
    exp_data = 0;
    exp_data_s = 0;
    check_cleared("rst_mid");
    #1;
    rst_i = 1'b0;
    idle_inputs();
    rd(2'd0, 0, 0, "rst_cycles");
    rd(2'd3, 0, 0, "rst_streak");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
